// File: rtl/traffic_light_fsm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tl_pkg
//  Purpose  : Shared state encoding and lamp codes for traffic_light_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
package tl_pkg;

    // Controller states; encodings are visible on state_o for debug.
    typedef enum logic [2:0] {
        NS_GRN = 3'd0,
        NS_YEL = 3'd1,
        RED_A  = 3'd2,
        EW_GRN = 3'd3,
        EW_YEL = 3'd4,
        RED_B  = 3'd5,
        WALK   = 3'd6
    } state_t;

    // Lamp drive codes; 2'b11 is never produced.
    localparam logic [1:0] LIGHT_RED = 2'b00;
    localparam logic [1:0] LIGHT_YEL = 2'b01;
    localparam logic [1:0] LIGHT_GRN = 2'b10;

endpackage
`default_nettype wire

// File: rtl/traffic_light_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : traffic_light_fsm_if
//  Purpose  : Tick/request inputs and lamp/debug outputs of the controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface traffic_light_fsm_if;
    logic       tick;
    logic       ped_req;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic [2:0] state_o;
    logic       phase_start;

    // Environment side: drives timebase and request, observes the lamps.
    modport master (
        output tick, ped_req,
        input  ns_light, ew_light, walk, state_o, phase_start
    );

    // Controller side.
    modport slave (
        input  tick, ped_req,
        output ns_light, ew_light, walk, state_o, phase_start
    );
endinterface
`default_nettype wire

// File: rtl/tick_dwell_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tick_dwell_counter
//  Purpose  : Counts timebase ticks spent in the current phase and flags the
//             tick that completes the phase duration.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_dwell_counter #(
    parameter int CW = 4
) (
    input  wire          clk,
    input  wire          R_n,
    input  wire          tick,
    input  wire          clr,
    input  wire [CW-1:0] dur,
    output logic         done
);

    logic [CW-1:0] dwell_q;
    logic [CW-1:0] dwell_d;

    // Dwell register; cleared on reset.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    // Clear on phase advance, otherwise count ticks; never reaches dur.
    always_comb begin
        dwell_d = dwell_q;
        if (clr) begin
            dwell_d = '0;
        end else if (tick) begin
            dwell_d = dwell_q + CW'(1);
        end
    end

    // Final tick of the phase.
    always_comb begin
        done = tick && (dwell_q == (dur - CW'(1)));
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : traffic_light_fsm
//  Purpose  : Tick-driven NS/EW intersection sequencer with all-red clearance
//             and an optional pedestrian walk phase.
//  Config   : PED_WALK_EN - when defined, latches ped_req and inserts WALK
//             after RED_B; when undefined, ped_req is ignored and walk = 0.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_fsm
    import tl_pkg::*;
#(
    parameter int CW           = 4,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int RED_TICKS    = 1,
    parameter int WALK_TICKS   = 5
) (
    input wire                 clk,
    input wire                 R_n,
    traffic_light_fsm_if.slave bus
);

    localparam int MAX_TICKS = (1 << CW) - 1;

    generate
        if (CW < 1 || CW > 30 ||
            GREEN_TICKS  < 1 || GREEN_TICKS  > MAX_TICKS ||
            YELLOW_TICKS < 1 || YELLOW_TICKS > MAX_TICKS ||
            RED_TICKS    < 1 || RED_TICKS    > MAX_TICKS ||
            WALK_TICKS   < 1 || WALK_TICKS   > MAX_TICKS) begin : g_param_check
            $error("traffic_light_fsm: phase durations must lie in 1..2^CW-1");
        end
    endgenerate

    localparam logic [CW-1:0] C_GREEN  = CW'(GREEN_TICKS);
    localparam logic [CW-1:0] C_YELLOW = CW'(YELLOW_TICKS);
    localparam logic [CW-1:0] C_RED    = CW'(RED_TICKS);
    localparam logic [CW-1:0] C_WALK   = CW'(WALK_TICKS);

    state_t        state_q;
    state_t        state_d;
    logic          phase_start_q;
    logic          phase_start_d;
    logic [CW-1:0] dur;
    logic          done;
    logic          ped_go;

    tick_dwell_counter #(
        .CW (CW)
    ) u_dwell (
        .clk  (clk),
        .R_n  (R_n),
        .tick (bus.tick),
        .clr  (done),
        .dur  (dur),
        .done (done)
    );

    // Duration of the phase currently being timed.
    always_comb begin
        case (state_q)
            NS_GRN, EW_GRN: dur = C_GREEN;
            NS_YEL, EW_YEL: dur = C_YELLOW;
            WALK:           dur = C_WALK;
            default:        dur = C_RED;
        endcase
    end

`ifdef PED_WALK_EN
    logic ped_pend_q;
    logic ped_pend_d;

    // Pending-walk latch.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end

    // Requests outside WALK are remembered; entering WALK consumes them and
    // drops any request arriving in that same cycle.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (bus.ped_req && (state_q != WALK)) begin
            ped_pend_d = 1'b1;
        end
        if (done && (state_q == RED_B) && ped_pend_q) begin
            ped_pend_d = 1'b0;
        end
    end

    assign ped_go = ped_pend_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = bus.ped_req;
    assign ped_go         = 1'b0;
`endif

    // State and phase_start registers.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q       <= NS_GRN;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_start_q <= phase_start_d;
        end
    end

    // Next state: advance only on the tick that completes the phase.
    always_comb begin
        state_d       = state_q;
        phase_start_d = done;
        if (done) begin
            case (state_q)
                NS_GRN:  state_d = NS_YEL;
                NS_YEL:  state_d = RED_A;
                RED_A:   state_d = EW_GRN;
                EW_GRN:  state_d = EW_YEL;
                EW_YEL:  state_d = RED_B;
                RED_B:   state_d = ped_go ? WALK : NS_GRN;
                default: state_d = NS_GRN;
            endcase
        end
    end

    // Moore lamp decode from the registered state.
    always_comb begin
        bus.ns_light    = LIGHT_RED;
        bus.ew_light    = LIGHT_RED;
        bus.walk        = 1'b0;
        bus.state_o     = state_q;
        bus.phase_start = phase_start_q;
        case (state_q)
            NS_GRN:  bus.ns_light = LIGHT_GRN;
            NS_YEL:  bus.ns_light = LIGHT_YEL;
            EW_GRN:  bus.ew_light = LIGHT_GRN;
            EW_YEL:  bus.ew_light = LIGHT_YEL;
`ifdef PED_WALK_EN
            WALK:    bus.walk     = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_fsm
//  Purpose  : Self-checking bench for traffic_light_fsm: phase-level reference
//             model compared every cycle, plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_fsm;

    localparam int CW = 4;
    localparam int G  = 8;
    localparam int Y  = 3;
    localparam int R  = 1;
    localparam int W  = 5;
`ifdef PED_WALK_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic clk = 1'b0;
    logic R_n = 1'b1;

    traffic_light_fsm_if bus ();

    traffic_light_fsm #(
        .CW           (CW),
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .RED_TICKS    (R),
        .WALK_TICKS   (W)
    ) dut (
        .clk (clk),
        .R_n (R_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus mode: 0 tick low, 1 tick high, 2 one tick per 7 clk, 3 random.
    int tick_mode = 0;
    bit ped_rand  = 1'b0;
    int cyc       = 0;
    bit chk_en    = 1'b0;

    // Phase-level reference: phase index 0..6 and ticks spent in it.
    int m_phase = 0;
    int m_cnt   = 0;
    bit m_pend  = 1'b0;
    bit m_ps    = 1'b0;
    bit m_pend_old;
    bit m_adv;
    int m_nxt;

    int run_st [8];
    int run_len[8];
    int run_next;

    function automatic int dur_of(input int p);
        case (p)
            0, 3:    return G;
            1, 4:    return Y;
            6:       return W;
            default: return R;
        endcase
    endfunction

    always @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
            m_ps    = 1'b0;
        end else begin
            m_pend_old = m_pend;
            m_adv      = bus.tick && (m_cnt + 1 == dur_of(m_phase));
            if (PED && bus.ped_req && m_phase != 6) m_pend = 1'b1;
            m_ps = m_adv;
            if (m_adv) begin
                if (m_phase == 5)      m_nxt = (PED && m_pend_old) ? 6 : 0;
                else if (m_phase == 6) m_nxt = 0;
                else                   m_nxt = m_phase + 1;
                if (m_nxt == 6) m_pend = 1'b0;
                m_phase = m_nxt;
                m_cnt   = 0;
            end else if (bus.tick) begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        int e_ns, e_ew, e_wk;
        if (chk_en) begin
            e_ns = (m_phase == 0) ? 2 : (m_phase == 1) ? 1 : 0;
            e_ew = (m_phase == 3) ? 2 : (m_phase == 4) ? 1 : 0;
            e_wk = (m_phase == 6) ? 1 : 0;
            checks++;
            if (int'(bus.ns_light) != e_ns || int'(bus.ew_light) != e_ew ||
                int'(bus.walk) != e_wk || int'(bus.state_o) != m_phase ||
                bus.phase_start != m_ps) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got ns=%0d ew=%0d walk=%0d st=%0d ps=%0d, want ns=%0d ew=%0d walk=%0d st=%0d ps=%0d",
                         $time, bus.ns_light, bus.ew_light, bus.walk, bus.state_o,
                         bus.phase_start, e_ns, e_ew, e_wk, m_phase, m_ps);
            end
        end
    end

    // Input driver, updated just after each falling edge.
    initial begin
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            case (tick_mode)
                0:       bus.tick = 1'b0;
                1:       bus.tick = 1'b1;
                2:       bus.tick = (cyc % 7 == 0);
                default: bus.tick = 1'($urandom_range(0, 1));
            endcase
            if (ped_rand) bus.ped_req = ($urandom_range(0, 19) == 0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic wait_entry(input int s);
        int g = 0;
        @(negedge clk);
        while (!(int'(bus.state_o) == s && bus.phase_start) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("wait_entry_%0d_timeout", s), (g < 3000) ? 1 : 0, 1);
    endtask

    // Records n consecutive (state, length-in-clk) runs starting at entry to s.
    task automatic capture_runs(input int s, input int n);
        int g   = 0;
        int k   = 0;
        int cur = s;
        int len = 1;
        wait_entry(s);
        while (k < n && g < 3000) begin
            @(negedge clk);
            g++;
            if (bus.phase_start) begin
                run_st[k]  = cur;
                run_len[k] = len;
                k++;
                cur = int'(bus.state_o);
                len = 1;
            end else begin
                len++;
            end
        end
        run_next = cur;
        chk("capture_timeout", (g < 3000) ? 1 : 0, 1);
    endtask

    initial begin
        int cnt;
        int g;
        int sum;
        int exp_len[6];
        exp_len = '{G, Y, R, G, Y, R};

        // Reset held with tick high.
        #1 R_n = 1'b0;
        chk_en    = 1'b1;
        tick_mode = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ns",    bus.ns_light, 2);
            chk("rst_ew",    bus.ew_light, 0);
            chk("rst_walk",  bus.walk, 0);
            chk("rst_state", bus.state_o, 0);
            chk("rst_ps",    bus.phase_start, 0);
        end
        @(negedge clk);
        #1 R_n = 1'b1;

        // Continuous tick: one full 24-clk cycle.
        capture_runs(0, 6);
        sum = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cyc_state_%0d", i), run_st[i], i);
            chk($sformatf("cyc_len_%0d", i), run_len[i], exp_len[i]);
            sum += run_len[i];
        end
        chk("cyc_period", sum, 24);
        chk("cyc_wrap", run_next, 0);

        // Sparse tick: NS_GRN lasts 8 ticks x 7 clk.
        @(negedge clk);
        tick_mode = 2;
        capture_runs(0, 1);
        chk("sparse_ns_grn_len", run_len[0], 56);

        // Reset in EW_YEL at dwell 1, then a full NS_GRN.
        @(negedge clk);
        tick_mode = 1;
        wait_entry(4);
        @(negedge clk);
        #1 R_n = 1'b0;
        #1;
        chk("midrst_ns",    bus.ns_light, 2);
        chk("midrst_ew",    bus.ew_light, 0);
        chk("midrst_state", bus.state_o, 0);
        tick_mode = 0;
        @(negedge clk);
        #1 R_n = 1'b1;
        @(negedge clk);
        tick_mode = 1;
        cnt = (int'(bus.state_o) == 0) ? 1 : 0;
        g = 0;
        @(negedge clk);
        while (int'(bus.state_o) == 0 && g < 100) begin
            cnt++;
            g++;
            @(negedge clk);
        end
        chk("postrst_ns_grn_len", cnt, G);

`ifdef PED_WALK_EN
        // Pulse in EW_GRN -> WALK after RED_B, then back to NS_GRN.
        wait_entry(3);
        #1 bus.ped_req = 1'b1;
        @(negedge clk);
        #1 bus.ped_req = 1'b0;
        capture_runs(4, 3);
        chk("ped_st0", run_st[0], 4);
        chk("ped_st1", run_st[1], 5);
        chk("ped_walk_state", run_st[2], 6);
        chk("ped_walk_len", run_len[2], W);
        chk("ped_after_walk", run_next, 0);
        capture_runs(4, 2);
        chk("ped_cleared", run_next, 0);

        // Request held through WALK re-latches once WALK exits.
        wait_entry(3);
        #1 bus.ped_req = 1'b1;
        @(negedge clk);
        #1 bus.ped_req = 1'b0;
        wait_entry(6);
        chk("held_walk_on", bus.walk, 1);
        #1 bus.ped_req = 1'b1;
        g = 0;
        @(negedge clk);
        while (int'(bus.state_o) == 6 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        #1 bus.ped_req = 1'b0;
        capture_runs(4, 2);
        chk("held_relatch", run_next, 6);

        // Single pulse inside WALK is dropped.
        #1 bus.ped_req = 1'b1;
        @(negedge clk);
        #1 bus.ped_req = 1'b0;
        capture_runs(4, 2);
        chk("inwalk_dropped", run_next, 0);
`endif

        // Randomized tick/request/reset traffic against the model.
        @(negedge clk);
        tick_mode = 3;
        ped_rand  = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 249) == 0) begin
                #1 R_n = 1'b0;
                @(negedge clk);
                #1 R_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
